// File: rtl/charattr_row_loader_if.sv
// charattr_row_loader_if: frame-memory read bus between the row loader and the memory arbiter
interface charattr_row_loader_if #(
   parameter int ADDR_WIDTH = 23
);
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic                  mem_valid;
   logic [31:0]           mem_data;
   modport master (output mem_req, mem_addr, input mem_ack, mem_valid, mem_data);
   modport slave  (input mem_req, mem_addr, output mem_ack, mem_valid, mem_data);
endinterface

// File: rtl/charattr_row_loader.sv
// charattr_row_loader: fetches one text row from frame memory into the char/attr row buffer
module charattr_row_loader #(
   parameter int COLUMNS     = 80,
   parameter int ADDR_WIDTH  = 23,
   parameter int MAX_PENDING = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_row_start,
   input  logic [5:0]            i_row_index,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   charattr_row_loader_if.master mem,
   output logic [6:0]            o_wr_addr,
   output logic [31:0]           o_wr_data,
   output logic                  o_wr_en,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_overrun
);
   localparam logic [7:0] COLS = 8'(COLUMNS);
   localparam logic [3:0] MAXP = 4'(MAX_PENDING);
   typedef enum logic [1:0] {IDLE, SETUP, FETCH} state_t;
   state_t                r_state, w_state_nx;
   logic [5:0]            r_index;
   logic [ADDR_WIDTH-1:0] r_base, r_row_addr, r_addr, w_row_addr;
   logic [7:0]            r_issued, r_received, w_issued_nx, w_received_nx;
   logic [3:0]            r_pending, w_pending_nx;
   logic                  r_req, r_wr_en, r_done, r_overrun;
   logic [6:0]            r_wr_addr;
   logic [31:0]           r_wr_data;
   logic                  w_ack, w_val, w_last;

   assign w_ack         = r_state == FETCH && r_req && mem.mem_ack;
   assign w_val         = r_state == FETCH && mem.mem_valid && r_pending != 4'd0;
   assign w_last        = w_val && r_received == COLS - 8'd1;
   assign w_row_addr    = r_base + ADDR_WIDTH'(r_index) * ADDR_WIDTH'(COLUMNS);
   assign w_issued_nx   = r_state == SETUP ? 8'd0 : r_issued + {7'd0, w_ack};
   assign w_received_nx = r_state == SETUP ? 8'd0 : r_received + {7'd0, w_val};
   assign w_pending_nx  = r_state == SETUP ? 4'd0 : r_pending + {3'd0, w_ack} - {3'd0, w_val};

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state == IDLE  ? (i_row_start ? SETUP : IDLE) :
                   r_state == SETUP ? FETCH : (w_last ? IDLE : FETCH);
   end

   always_comb begin
      o_busy       = r_state != IDLE;
      mem.mem_req  = r_req;
      mem.mem_addr = r_addr;
      o_wr_en      = r_wr_en;
      o_wr_addr    = r_wr_addr;
      o_wr_data    = r_wr_data;
      o_done       = r_done;
      o_overrun    = r_overrun;
   end

   // request is recomputed from post-edge counters, so it only falls on an ack or at row end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_index    <= '0;
         r_base     <= '0;
         r_row_addr <= '0;
         r_addr     <= '0;
         r_issued   <= '0;
         r_received <= '0;
         r_pending  <= '0;
         r_req      <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (r_state == IDLE && i_row_start) begin
            r_index <= i_row_index;
            r_base  <= i_base_addr;
         end
         if (r_state == SETUP) r_row_addr <= w_row_addr;
         r_issued   <= w_issued_nx;
         r_received <= w_received_nx;
         r_pending  <= w_pending_nx;
         r_req      <= w_state_nx == FETCH && w_issued_nx < COLS && w_pending_nx < MAXP;
         r_addr     <= (r_state == SETUP ? w_row_addr : r_row_addr) + ADDR_WIDTH'(w_issued_nx);
         r_wr_en    <= w_val;
         if (w_val) begin
            r_wr_addr <= r_received[6:0];
            r_wr_data <= mem.mem_data;
         end
         r_done     <= w_last;
         r_overrun  <= i_row_start && r_state != IDLE;
      end
   end
endmodule
